mii_rx_frame_assembler: RTL and testbench



---
 rtl/mii_rx_frame_assembler.sv | 137 +++++++++++++
 tb/tb_mii_rx_frame_assembler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mii_rx_frame_assembler.sv
// mii_rx_frame_assembler: strips MII preamble/SFD and assembles nibbles into a byte AXI-stream
// Optional feature macro: MII_RX_LEN_CHECK_EN (flags frames shorter than MIN_FRAME_LEN or longer than MAX_FRAME_LEN)
// Ports:
//   clk, rst_n                  receive clock, asynchronous active-low reset
//   mii_rxd/mii_rx_dv/mii_rx_er captured MII receive nibble, data valid, receive error
//   m_axis_tdata/tvalid/tlast   received byte, single-cycle strobe, last byte of frame
//   m_axis_tuser                frame bad, qualified by tlast
//   stat_rx_bad_frame           pulse with a bad last beat
//   stat_rx_preamble_err        pulse when a malformed preamble starts being dropped
module mii_rx_frame_assembler #(
    parameter int MIN_PREAMBLE_NIBBLES = 2
`ifdef MII_RX_LEN_CHECK_EN
    ,
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] mii_rxd,
    input  logic       mii_rx_dv,
    input  logic       mii_rx_er,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       stat_rx_bad_frame,
    output logic       stat_rx_preamble_err
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;
    localparam logic [3:0] MIN_PRE = 4'(MIN_PREAMBLE_NIBBLES);
    state_t     state;
    logic [3:0] pre_cnt;
    logic [3:0] low_nib;
    logic [7:0] hold;
    logic       hold_full;
    logic       phase;
    logic       err;
    logic       len_bad;
    logic       sfd_ok;
    logic       end_bad;
    assign sfd_ok = state == PREAMBLE && mii_rx_dv && !mii_rx_er && mii_rxd == 4'hD && pre_cnt >= MIN_PRE;
    // An empty hold register at frame end means no whole byte arrived; phase 1 means a dangling nibble
    assign end_bad = !hold_full | err | phase | len_bad;
`ifdef MII_RX_LEN_CHECK_EN
    localparam logic [11:0] MIN_LEN = 12'(MIN_FRAME_LEN);
    localparam logic [11:0] MAX_LEN = 12'(MAX_FRAME_LEN);
    logic [11:0] len;
    assign len_bad = len < MIN_LEN || len > MAX_LEN;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            len <= '0;
        else if (sfd_ok)
            len <= '0;
        else if (state == PAYLOAD && mii_rx_dv && phase && len != 12'hFFF)
            len <= len + 12'd1;
`else
    assign len_bad = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            pre_cnt              <= '0;
            low_nib              <= '0;
            hold                 <= '0;
            hold_full            <= 1'b0;
            phase                <= 1'b0;
            err                  <= 1'b0;
            m_axis_tdata         <= '0;
            m_axis_tvalid        <= 1'b0;
            m_axis_tlast         <= 1'b0;
            m_axis_tuser         <= 1'b0;
            stat_rx_bad_frame    <= 1'b0;
            stat_rx_preamble_err <= 1'b0;
        end else begin
            m_axis_tvalid        <= 1'b0;
            m_axis_tlast         <= 1'b0;
            m_axis_tuser         <= 1'b0;
            stat_rx_bad_frame    <= 1'b0;
            stat_rx_preamble_err <= 1'b0;
            case (state)
                IDLE:
                    if (mii_rx_dv) begin
                        if (mii_rxd == 4'h5) begin
                            state   <= PREAMBLE;
                            pre_cnt <= 4'd1;
                        end else begin
                            state                <= DROP;
                            stat_rx_preamble_err <= 1'b1;
                        end
                    end
                PREAMBLE:
                    if (!mii_rx_dv)
                        state <= IDLE;
                    else if (sfd_ok) begin
                        state     <= PAYLOAD;
                        phase     <= 1'b0;
                        err       <= 1'b0;
                        hold_full <= 1'b0;
                    end else if (!mii_rx_er && mii_rxd == 4'h5)
                        pre_cnt <= pre_cnt + {3'b0, pre_cnt != 4'hF};
                    else begin
                        state                <= DROP;
                        stat_rx_preamble_err <= 1'b1;
                    end
                PAYLOAD:
                    if (mii_rx_dv) begin
                        if (mii_rx_er)
                            err <= 1'b1;
                        phase <= ~phase;
                        if (!phase)
                            low_nib <= mii_rxd;
                        else begin
                            // Hold one byte back so the final byte can carry tlast
                            if (hold_full) begin
                                m_axis_tdata  <= hold;
                                m_axis_tvalid <= 1'b1;
                            end
                            hold      <= {mii_rxd, low_nib};
                            hold_full <= 1'b1;
                        end
                    end else begin
                        state             <= IDLE;
                        hold_full         <= 1'b0;
                        m_axis_tdata      <= hold_full ? hold : 8'h00;
                        m_axis_tvalid     <= 1'b1;
                        m_axis_tlast      <= 1'b1;
                        m_axis_tuser      <= end_bad;
                        stat_rx_bad_frame <= end_bad;
                    end
                default:
                    if (!mii_rx_dv)
                        state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mii_rx_frame_assembler.sv
// tb_mii_rx_frame_assembler: table-driven check of the MII receive frame assembler
module tb_mii_rx_frame_assembler;
`ifdef MII_RX_LEN_CHECK_EN
    localparam logic LEN = 1'b1;
`else
    localparam logic LEN = 1'b0;
`endif
    typedef struct {
        logic       dv;
        logic       er;
        logic [3:0] rxd;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       u;
        logic       b;
        logic       p;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] mii_rxd;
    logic       mii_rx_dv;
    logic       mii_rx_er;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       stat_rx_bad_frame;
    logic       stat_rx_preamble_err;
    int         errors = 0;
    int         checks = 0;
    int         idx = 0;
    vec_t       q[$];
    always #5 clk = ~clk;
    mii_rx_frame_assembler dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mii_rxd             (mii_rxd),
        .mii_rx_dv           (mii_rx_dv),
        .mii_rx_er           (mii_rx_er),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tlast        (m_axis_tlast),
        .m_axis_tuser        (m_axis_tuser),
        .stat_rx_bad_frame   (stat_rx_bad_frame),
        .stat_rx_preamble_err(stat_rx_preamble_err)
    );
    function automatic vec_t mk(logic dv, logic er, logic [3:0] rxd, logic v, logic [7:0] d,
                                logic l, logic u, logic b, logic p);
        vec_t t;
        t.dv = dv; t.er = er; t.rxd = rxd; t.v = v; t.d = d; t.l = l; t.u = u; t.b = b; t.p = p;
        return t;
    endfunction
    function automatic void add(logic dv, logic er, logic [3:0] rxd, logic v, logic [7:0] d,
                                logic l, logic u, logic b, logic p);
        q.push_back(mk(dv, er, rxd, v, d, l, u, b, p));
    endfunction
    function automatic void quiet(logic dv, logic er, logic [3:0] rxd);
        add(dv, er, rxd, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic void pre(int n);
        for (int i = 0; i < n; i++) quiet(1, 0, 4'h5);
        quiet(1, 0, 4'hD);
    endfunction
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %02h expected %02h", nm, idx, act, exp);
        end
    endtask
    // ctl vector packs {tvalid, tlast, tuser, stat_rx_bad_frame, stat_rx_preamble_err}
    task automatic run(input vec_t t);
        mii_rx_dv = t.dv;
        mii_rx_er = t.er;
        mii_rxd   = t.rxd;
        @(negedge clk);
        chk("ctl", {3'b0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, stat_rx_bad_frame, stat_rx_preamble_err},
            {3'b0, t.v, t.l, t.u, t.b, t.p});
        if (t.v) chk("tdata", m_axis_tdata, t.d);
        idx++;
    endtask
    initial begin
        rst_n = 1'b0; mii_rx_dv = 1'b0; mii_rx_er = 1'b0; mii_rxd = 4'h0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {3'b0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, stat_rx_bad_frame, stat_rx_preamble_err}, 8'h00);
        chk("reset_data", m_axis_tdata, 8'h00);
        rst_n = 1'b1;
        // good frame with 15 preamble nibbles
        quiet(0, 0, 0); pre(15);
        quiet(1, 0, 1); quiet(1, 0, 0); quiet(1, 0, 2); add(1, 0, 0, 1, 8'h01, 0, 0, 0, 0);
        quiet(1, 0, 3); add(1, 0, 0, 1, 8'h02, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'h03, 1, LEN, LEN, 0); quiet(0, 0, 0);
        // same frame with rx_er on nibble 2
        pre(15);
        quiet(1, 0, 1); quiet(1, 0, 0); quiet(1, 1, 2); add(1, 0, 0, 1, 8'h01, 0, 0, 0, 0);
        quiet(1, 0, 3); add(1, 0, 0, 1, 8'h02, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'h03, 1, 1, 1, 0); quiet(0, 0, 0);
        // dangling odd nibble
        pre(7);
        quiet(1, 0, 1); quiet(1, 0, 0); quiet(1, 0, 2);
        add(0, 0, 0, 1, 8'h01, 1, 1, 1, 0); quiet(0, 0, 0);
        // bad preamble dropped, then good frame after one-clock gap, then back-to-back frame
        quiet(1, 0, 5); quiet(1, 0, 5); add(1, 0, 4'h7, 0, 8'h00, 0, 0, 0, 1);
        quiet(1, 0, 5); quiet(1, 0, 4'hD); quiet(1, 0, 1); quiet(1, 0, 0); quiet(0, 0, 0);
        pre(2);
        quiet(1, 0, 4'hA); quiet(1, 0, 4'hB); quiet(1, 0, 4'hC); add(1, 0, 4'hD, 1, 8'hBA, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'hDC, 1, LEN, LEN, 0);
        pre(2);
        quiet(1, 0, 4'hE); quiet(1, 0, 4'hF);
        add(0, 0, 0, 1, 8'hFE, 1, LEN, LEN, 0); quiet(0, 0, 0);
        // SFD then immediate end
        pre(2); add(0, 0, 0, 1, 8'h00, 1, 1, 1, 0); quiet(0, 0, 0);
        // single nibble after SFD
        pre(2); quiet(1, 0, 7); add(0, 0, 0, 1, 8'h00, 1, 1, 1, 0); quiet(0, 0, 0);
        // dv falls during preamble: silent
        quiet(1, 0, 5); quiet(1, 0, 5); quiet(1, 0, 5); quiet(0, 0, 0); quiet(0, 0, 0);
        // SFD too early
        quiet(1, 0, 5); add(1, 0, 4'hD, 0, 8'h00, 0, 0, 0, 1); quiet(1, 0, 1); quiet(0, 0, 0);
        // rx_er during preamble
        quiet(1, 0, 5); quiet(1, 0, 5); add(1, 1, 4'h5, 0, 8'h00, 0, 0, 0, 1); quiet(0, 0, 0);
        // 10-byte frame: short only when the length check is built
        pre(2);
        for (int i = 0; i < 10; i++) begin
            quiet(1, 0, 4'(i));
            if (i == 0) quiet(1, 0, 0);
            else add(1, 0, 0, 1, 8'(i - 1), 0, 0, 0, 0);
        end
        add(0, 0, 0, 1, 8'h09, 1, LEN, LEN, 0); quiet(0, 0, 0);
        foreach (q[i]) run(q[i]);
        // asynchronous reset mid-payload, released while dv is still high
        run(mk(1, 0, 5, 0, 0, 0, 0, 0, 0)); run(mk(1, 0, 5, 0, 0, 0, 0, 0, 0));
        run(mk(1, 0, 4'hD, 0, 0, 0, 0, 0, 0));
        run(mk(1, 0, 1, 0, 0, 0, 0, 0, 0)); run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        run(mk(1, 0, 2, 0, 0, 0, 0, 0, 0)); run(mk(1, 0, 0, 1, 8'h01, 0, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1 chk("async_reset_ctl", {3'b0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, stat_rx_bad_frame, stat_rx_preamble_err}, 8'h00);
        chk("async_reset_data", m_axis_tdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run(mk(1, 0, 1, 0, 0, 0, 0, 0, 1));
        run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0)); run(mk(1, 0, 5, 0, 0, 0, 0, 0, 0));
        run(mk(1, 0, 4'hD, 0, 0, 0, 0, 0, 0)); run(mk(1, 0, 3, 0, 0, 0, 0, 0, 0));
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        run(mk(1, 0, 5, 0, 0, 0, 0, 0, 0)); run(mk(1, 0, 5, 0, 0, 0, 0, 0, 0));
        run(mk(1, 0, 4'hD, 0, 0, 0, 0, 0, 0)); run(mk(1, 0, 3, 0, 0, 0, 0, 0, 0));
        run(mk(1, 0, 4, 0, 0, 0, 0, 0, 0));
        run(mk(0, 0, 0, 1, 8'h43, 1, LEN, LEN, 0));
        run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
